// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store initiator issuing one single-cycle access to byte-addressed data memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of issuing them.
module lsu_mem_ctrl #(
    parameter int DMEM_ADDR  = 13,
    parameter int DMEM_DEPTH = 201,
    parameter int CNT_W      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [31:0]          i_req_addr,
    input  logic [31:0]          i_req_wdata,
    input  logic [2:0]           i_req_funct,
    output logic [DMEM_ADDR-1:0] o_lsu_addr,
    output logic                 o_penable,
    output logic                 o_pwrite,
    output logic [31:0]          o_pwdata,
    output logic [2:0]           o_pfunct_code,
    input  logic [31:0]          i_prdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_rdata,
    output logic                 o_rsp_err,
    output logic [CNT_W-1:0]     o_load_cnt,
    output logic [CNT_W-1:0]     o_store_cnt
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
    logic [1:0]           state;
    logic                 r_we, err;
    logic [DMEM_ADDR-1:0] r_addr;
    logic [31:0]          r_wdata, rdata;
    logic [2:0]           r_funct;
    logic [CNT_W-1:0]     load_cnt, store_cnt;
    logic                 funct_ok, range_ok, align_ok, req_ok;
    logic [32:0]          last_byte;
    always_comb begin
        funct_ok  = i_req_we ? (!i_req_funct[2] && i_req_funct[1:0] != 2'b11)
                             : (i_req_funct[1:0] != 2'b11 && i_req_funct[2:1] != 2'b11);
        // full 32-bit address plus access size, so wrap-around near 2^32 still faults
        last_byte = {1'b0, i_req_addr} + (i_req_funct[1] ? 33'd3 : i_req_funct[0] ? 33'd1 : 33'd0);
        range_ok  = last_byte < 33'(DMEM_DEPTH);
`ifdef LSU_MISALIGN_TRAP_EN
        align_ok  = !(i_req_funct[1] ? |i_req_addr[1:0] : (i_req_funct[0] & i_req_addr[0]));
`else
        align_ok  = 1'b1;
`endif
        req_ok    = funct_ok && range_ok && align_ok;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_funct   <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (i_req_valid) begin
                    r_we    <= i_req_we;
                    r_addr  <= i_req_addr[DMEM_ADDR-1:0];
                    r_wdata <= i_req_wdata;
                    r_funct <= i_req_funct;
                    rdata   <= '0;
                    err     <= !req_ok;
                    state   <= req_ok ? ACCESS : RESP;
                end
                ACCESS: begin
                    rdata <= r_we ? '0 : i_prdata;
                    state <= RESP;
                end
                RESP: if (i_rsp_ready) begin
                    state <= IDLE;
                    if (!err && r_we && !(&store_cnt)) store_cnt <= store_cnt + 1'b1;
                    if (!err && !r_we && !(&load_cnt)) load_cnt <= load_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign o_req_ready   = state == IDLE;
    assign o_penable     = state == ACCESS;
    assign o_pwrite      = o_penable && r_we;
    assign o_lsu_addr    = o_penable ? r_addr : '0;
    assign o_pwdata      = o_penable ? r_wdata : '0;
    assign o_pfunct_code = o_penable ? r_funct : '0;
    assign o_rsp_valid   = state == RESP;
    assign o_rsp_rdata   = o_rsp_valid ? rdata : '0;
    assign o_rsp_err     = o_rsp_valid && err;
    assign o_load_cnt    = load_cnt;
    assign o_store_cnt   = store_cnt;
endmodule
